rvc_fetch_aligner: RTL and testbench
====================================

# rvc_fetch_aligner

Parametrised RV32IC instruction-fetch front end that sits between the I-cache and the IF/ID pipeline register. Fetches aligned 32-bit words, buffers them as halfwords in a DEPTH-entry queue, and presents one aligned instruction per cycle, either 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary. It replaces the fixed single-halfword buffer and COMPLETE/INCOMPLETE/PREPARE state scheme with a configurable queue, a ready/valid downstream handshake and single-cycle redirect.

## Interface
Parameters:
- DEPTH, 8: queue capacity in halfwords; power of 2, ≥4.
- RESET_PC, 32'h0000_0000: first fetch address; halfword aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ICACHE_ren  out  1  fetch request.
- ICACHE_addr  out  30  word address, fetch_pc[31:2].
- ICACHE_stall  in  1  cache busy; rdata is not valid while high.
- ICACHE_rdata  in  32  fetched word, byte-swapped: memory byte 0 is in [31:24].
- redirect_valid  in  1  flush and restart fetch; from branch/jump resolution.
- redirect_pc  in  32  restart address; bit 0 is ignored.
- instr_valid  out  1  instr_o holds a complete instruction.
- instr_ready  in  1  consumer accepts; low means IF stall.
- instr_o  out  32  instruction; compressed instructions zero-extended in [31:16].
- instr_pc  out  32  address of instr_o.
- instr_compressed  out  1  instr_o[1:0] != 2'b11.

## Operation
- State:
  - fetch_pc: word aligned.
  - skip_lo: drop the low halfword of the next accepted word.
  - Circular halfword queue with rd_ptr, wr_ptr and count (width clog2(DEPTH)+1). Pointers wrap modulo DEPTH.
  - head_pc.
- Endianness: the block byte-swaps rdata into little-endian word w. Low halfword is w[15:0], at lower address.
- Fetch accepted when ICACHE_ren=1 and ICACHE_stall=0 in the same cycle.
  - Push w[15:0] then w[31:16]; push only w[31:16] if skip_lo.
  - Then clear skip_lo and advance fetch_pc by 4.
- ICACHE_ren = (DEPTH − count ≥ 2) and no redirect_valid. Uses count at the start of the cycle, with no dependency on instr_ready.
- Head decode:
  - q[rd_ptr][1:0] != 11: compressed. instr_valid when count ≥ 1; instr_o = {16'h0, q[rd]}.
  - Otherwise 32-bit. instr_valid when count ≥ 2; instr_o = {q[rd+1], q[rd]}.
  - A straddling 32-bit instruction with only its low half queued stays invalid until the next fetch lands.
- Pop when instr_valid and instr_ready: 1 halfword if compressed, else 2. head_pc advances by 2 or 4.
- Same-cycle push and pop: count_next = count + pushed − popped.
- Redirect has priority over push and pop. On the clock edge:
  - count becomes 0 and pointers reset.
  - fetch_pc becomes {redirect_pc[31:2], 2'b00}; skip_lo becomes redirect_pc[1]; head_pc becomes {redirect_pc[31:1], 1'b0}.
  - Any data returned that cycle is discarded.
- Redirect during ICACHE_stall: the stalled request is abandoned. The new address is presented the next cycle.

## Timing
- Reset (async, immediate, including mid-operation):
  - fetch_pc = RESET_PC with low 2 bits cleared; skip_lo = RESET_PC[1]; head_pc = RESET_PC; count = 0.
  - Outputs: instr_valid=0, instr_o=0, instr_pc=RESET_PC, instr_compressed=0.
  - ICACHE_ren=1 and ICACHE_addr=RESET_PC[31:2] from the first cycle after rst_n rises.
- Fetch-to-output latency: 1 cycle. Word accepted at edge N gives instr_valid from cycle N+1.
- Redirect to first ICACHE_ren: the cycle after redirect_valid. First instr_valid is 1 cycle after that fetch is accepted.
- Sustained throughput: 1 instruction/cycle while fetches keep the queue ≥ 2.
- Full: count ≥ DEPTH−1 gives ICACHE_ren=0. No overflow is possible.
- Empty: instr_valid=0. instr_o holds its last value.
- instr_valid does not depend combinationally on instr_ready.

## Configuration
- RVC_FETCH_BYPASS_EN defined:
  - When the queue holds no usable instruction and a fetch is accepted, the instruction is forwarded from rdata combinationally in the same cycle.
  - Fetch-to-output latency becomes 0.
  - Whatever is not consumed is queued as normal.
  - The rdata → instr_valid/instr_o path is combinational.
- Undefined: the output is registered only from the queue; latency is 1 cycle as in Timing.

## Test plan
- Reset with RESET_PC=0; memory word 0 = 0x00500093 (addi x1,x0,5):
  - ICACHE_addr=0 in the first cycle.
  - Next cycle: instr_valid=1, instr_o=0x00500093, instr_pc=0, instr_compressed=0.
- Word 0 = {0x0001 c.nop at [15:0], low half of 0x00A00113 at [31:16]}, word 1 = {high half, 0x4505}:
  - Outputs in order: 0x00000001 @0 (c), 0x00A00113 @2 (32-bit, straddling), 0x00004505 @6 (c).
- redirect_valid with redirect_pc=0x102:
  - Next cycle ICACHE_addr=0x40.
  - Only rdata[31:16] is queued; first instr_pc=0x102; prior queue contents are never output.
- instr_ready=0 for 20 cycles with all-compressed code, DEPTH=8:
  - count saturates at 7 or 8; ICACHE_ren drops when count ≥ 7; no halfword is lost or duplicated after ready returns.
- ICACHE_stall high for 3 cycles, then redirect_valid in the 2nd stall cycle:
  - The stalled word is never queued; ICACHE_addr shows the redirect target next cycle.
- Assert rst_n low while count=5 and a 32-bit instruction is half queued:
  - Outputs clear immediately, without a clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: RV32IC fetch front end between the I-cache and IF/ID.
// Fetches aligned 32-bit words, queues them as halfwords in a DEPTH-entry
// circular buffer and presents one aligned instruction per cycle, 16-bit
// compressed or 32-bit, including 32-bit instructions straddling a word.
// Optional feature macro: RVC_FETCH_BYPASS_EN forwards a freshly fetched
// instruction combinationally when the queue holds no usable instruction.
module rvc_fetch_aligner #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    input  logic        ICACHE_stall,
    input  logic [31:0] ICACHE_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc,
    output logic        instr_compressed
);

    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // The cache delivers memory byte 0 in [31:24]; restore little-endian order.
    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // A halfword starts a compressed instruction unless its low bits are 11.
    function automatic logic is_rvc(input logic [15:0] h);
        return (h[1:0] != 2'b11);
    endfunction

    logic [15:0]   q_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [29:0]   fetch_word_r;
    logic          skip_lo_r;
    logic [31:0]   head_pc_r;
    logic [31:0]   last_instr_r;

    logic [31:0]   w_s;
    logic [CW-1:0] free_s;
    logic [CW-1:0] avail_s;
    logic          accept_s;
    logic [1:0]    push_n_s;
    logic [1:0]    pop_n_s;
    logic [PW-1:0] rd1_s;
    logic [PW-1:0] wr1_s;
    logic [15:0]   v0_s;
    logic [15:0]   v1_s;
    logic          head_rvc_s;
    logic          valid_s;
    logic [31:0]   view_s;
    logic          unused_ok_s;
`ifdef RVC_FETCH_BYPASS_EN
    logic [15:0]   in0_s;
    logic [15:0]   in1_s;
`endif

    // Fetch request, acceptance and number of halfwords pushed this cycle
    always_comb begin
        w_s         = byte_swap(ICACHE_rdata);
        free_s      = DEPTH_C - count_r;
        ICACHE_ren  = (free_s >= CW'(2)) && !redirect_valid;
        ICACHE_addr = fetch_word_r;
        accept_s    = ICACHE_ren && !ICACHE_stall;
        if (!accept_s) begin
            push_n_s = 2'd0;
        end else if (skip_lo_r) begin
            push_n_s = 2'd1;
        end else begin
            push_n_s = 2'd2;
        end
        wr1_s = wr_ptr_r + PW'(1);
        rd1_s = rd_ptr_r + PW'(1);
    end

    // Head-of-stream view, decode, pop amount and output drive
    always_comb begin
`ifdef RVC_FETCH_BYPASS_EN
        // Queued halfwords come first, the word arriving this cycle follows.
        in0_s   = skip_lo_r ? w_s[31:16] : w_s[15:0];
        in1_s   = w_s[31:16];
        avail_s = count_r + CW'(push_n_s);
        if (count_r >= CW'(2)) begin
            v0_s = q_r[rd_ptr_r];
            v1_s = q_r[rd1_s];
        end else if (count_r == CW'(1)) begin
            v0_s = q_r[rd_ptr_r];
            v1_s = in0_s;
        end else begin
            v0_s = in0_s;
            v1_s = in1_s;
        end
`else
        avail_s = count_r;
        v0_s    = q_r[rd_ptr_r];
        v1_s    = q_r[rd1_s];
`endif
        head_rvc_s = is_rvc(v0_s);
        if (head_rvc_s) begin
            valid_s = (avail_s >= CW'(1));
            view_s  = {16'h0000, v0_s};
        end else begin
            valid_s = (avail_s >= CW'(2));
            view_s  = {v1_s, v0_s};
        end
        if (valid_s && instr_ready) begin
            pop_n_s = head_rvc_s ? 2'd1 : 2'd2;
        end else begin
            pop_n_s = 2'd0;
        end
        instr_valid      = valid_s;
        instr_o          = valid_s ? view_s : last_instr_r;
        instr_compressed = valid_s && head_rvc_s;
        instr_pc         = head_pc_r;
        // Bit 0 of the redirect target is architecturally meaningless.
        unused_ok_s      = redirect_pc[0];
    end

    // Queue pointers, occupancy, fetch address and head PC; redirect wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r     <= {PW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            fetch_word_r <= RESET_PC[31:2];
            skip_lo_r    <= RESET_PC[1];
            head_pc_r    <= RESET_PC;
        end else if (redirect_valid) begin
            rd_ptr_r     <= {PW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            fetch_word_r <= redirect_pc[31:2];
            skip_lo_r    <= redirect_pc[1];
            head_pc_r    <= {redirect_pc[31:1], 1'b0};
        end else begin
            wr_ptr_r  <= wr_ptr_r + PW'(push_n_s);
            rd_ptr_r  <= rd_ptr_r + PW'(pop_n_s);
            count_r   <= count_r + CW'(push_n_s) - CW'(pop_n_s);
            head_pc_r <= head_pc_r + {29'd0, pop_n_s, 1'b0};
            if (accept_s) begin
                fetch_word_r <= fetch_word_r + 30'd1;
                skip_lo_r    <= 1'b0;
            end
        end
    end

    // Halfword storage: write the accepted word's halfwords at wr_ptr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_r[i] <= 16'h0000;
            end
        end else if (!redirect_valid && (push_n_s != 2'd0)) begin
            if (skip_lo_r) begin
                q_r[wr_ptr_r] <= w_s[31:16];
            end else begin
                q_r[wr_ptr_r] <= w_s[15:0];
                q_r[wr1_s]    <= w_s[31:16];
            end
        end
    end

    // Hold the last presented instruction so instr_o is stable while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_instr_r <= 32'h0000_0000;
        end else if (valid_s) begin
            last_instr_r <= view_s;
        end
    end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Self-checking bench for rvc_fetch_aligner (DEPTH=8, RESET_PC=0).
// A behavioural I-cache returns byte-swapped words from a small memory;
// expected instructions are queued when a stream is started and compared
// as the DUT hands them over.
module tb_rvc_fetch_aligner;

    logic        clk;
    logic        rst_n;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic        ICACHE_stall;
    logic [31:0] ICACHE_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_o;
    logic [31:0] instr_pc;
    logic        instr_compressed;

    rvc_fetch_aligner #(.DEPTH(8), .RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ICACHE_ren       (ICACHE_ren),
        .ICACHE_addr      (ICACHE_addr),
        .ICACHE_stall     (ICACHE_stall),
        .ICACHE_rdata     (ICACHE_rdata),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_o          (instr_o),
        .instr_pc         (instr_pc),
        .instr_compressed (instr_compressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [29:0] addr;
        logic [31:0] instr;
        logic        c;
        int          lat;
    } vec_t;

    logic [31:0] mem [0:255];
    exp_t        sb_q [$];
    vec_t        vecs [7];
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic set_rdata();
        logic [31:0] w;
        w = mem[ICACHE_addr[7:0]];
        ICACHE_rdata = {w[7:0], w[15:8], w[23:16], w[31:24]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        set_rdata();
        #1;
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Reference decode: walk memory from pc and queue n expected instructions
    task automatic push_model(input logic [31:0] start, input int n);
        logic [31:0] pc;
        logic [15:0] h;
        exp_t        e;
        pc = start;
        for (int i = 0; i < n; i++) begin
            h = hw_at(pc);
            if (h[1:0] != 2'b11) begin
                e.instr = {16'h0000, h};
                e.pc    = pc;
                e.c     = 1'b1;
                pc      = pc + 32'd2;
            end else begin
                e.instr = {hw_at(pc + 32'd2), h};
                e.pc    = pc;
                e.c     = 1'b0;
                pc      = pc + 32'd4;
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc, input logic c);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.c     = c;
        sb_q.push_back(e);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
        sb_q.delete();
        #1;
    endtask

    task automatic drain(input bit rnd);
        int cyc;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 500) begin
            if (rnd) begin
                instr_ready  = ($urandom_range(0, 3) != 0);
                ICACHE_stall = ($urandom_range(0, 3) == 0);
            end else begin
                instr_ready  = 1'b1;
                ICACHE_stall = 1'b0;
            end
            tick();
            cyc++;
        end
        chk("drain_left", 32'(sb_q.size()), 32'd0);
        instr_ready  = 1'b0;
        ICACHE_stall = 1'b0;
    endtask

    // Scoreboard: compare every handed-over instruction against the queue
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && instr_valid && instr_ready && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            if (instr_o !== e.instr || instr_pc !== e.pc || instr_compressed !== e.c) begin
                errors++;
                $display("FAIL sb_out: got %08h@%08h c=%0b expected %08h@%08h c=%0b",
                         instr_o, instr_pc, instr_compressed, e.instr, e.pc, e.c);
            end
        end
    end

    initial begin
        int lat;
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b1;
        instr_ready    = 1'b0;
        ICACHE_stall   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        ICACHE_rdata   = 32'h0000_0000;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]  = 32'h0050_0093;               // addi x1,x0,5
        mem[8]  = 32'h0113_0001;               // c.nop, low half of addi x2
        mem[9]  = 32'h4505_00A0;               // high half of addi x2, c.li
        for (int j = 0; j < 16; j++) begin     // all-compressed region at 0x40
            mem[16 + j] = {16'h4001 + 16'((2 * j + 1) * 4), 16'h4001 + 16'((2 * j) * 4)};
        end
        mem[40] = 32'h4009_1234;
        mem[41] = 32'h4011_400D;
        mem[42] = 32'h0513_4015;               // low half of addi a0 at 0xAA
        mem[43] = 32'h4019_00A0;
        mem[56] = 32'hDEAD_BEEF;               // word that is stalled then abandoned
        mem[64] = 32'h4585_0001;               // only 0x4585 at 0x102 is wanted

        vecs[0] = '{32'h0000_0000, 30'h000, 32'h0050_0093, 1'b0, 1};
        vecs[1] = '{32'h0000_0020, 30'h008, 32'h0000_0001, 1'b1, 1};
        vecs[2] = '{32'h0000_0022, 30'h008, 32'h00A0_0113, 1'b0, 2};
        vecs[3] = '{32'h0000_0026, 30'h009, 32'h0000_4505, 1'b1, 1};
        vecs[4] = '{32'h0000_0102, 30'h040, 32'h0000_4585, 1'b1, 1};
        vecs[5] = '{32'h0000_0040, 30'h010, 32'h0000_4001, 1'b1, 1};
        vecs[6] = '{32'h0000_0042, 30'h010, 32'h0000_4005, 1'b1, 1};

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr_o, 32'h0000_0000);
        chk("rst_pc", instr_pc, 32'h0000_0000);
        chk("rst_c", 32'(instr_compressed), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        set_rdata();
        #1;
        chk("boot_ren", 32'(ICACHE_ren), 32'd1);
        chk("boot_addr", 32'(ICACHE_addr), 32'd0);
        tick();
        chk("boot_valid", 32'(instr_valid), 32'd1);
        chk("boot_instr", instr_o, 32'h0050_0093);
        chk("boot_pc", instr_pc, 32'h0000_0000);
        chk("boot_c", 32'(instr_compressed), 32'd0);

        // Table: first instruction after a redirect, address and latency
        for (int i = 0; i < 7; i++) begin
            redirect_to(vecs[i].pc);
            chk("vec_addr", 32'(ICACHE_addr), 32'(vecs[i].addr));
            chk("vec_flush", 32'(instr_valid), 32'd0);
            lat = 0;
            while (!instr_valid && lat < 10) begin
                tick();
                lat++;
            end
            chk("vec_lat", 32'(lat), 32'(vecs[i].lat));
            chk("vec_instr", instr_o, vecs[i].instr);
            chk("vec_pc", instr_pc, vecs[i].pc);
            chk("vec_c", 32'(instr_compressed), 32'(vecs[i].c));
        end

        // Straddling 32-bit instruction between two compressed ones
        redirect_to(32'h0000_0020);
        push_exp(32'h0000_0001, 32'h0000_0020, 1'b1);
        push_exp(32'h00A0_0113, 32'h0000_0022, 1'b0);
        push_exp(32'h0000_4505, 32'h0000_0026, 1'b1);
        drain(1'b0);

        // Redirect to an odd halfword: low half of the word must be dropped
        redirect_to(32'h0000_0102);
        chk("redir_addr", 32'(ICACHE_addr), 32'h0000_0040);
        push_exp(32'h0000_4585, 32'h0000_0102, 1'b1);
        drain(1'b0);

        // Backpressure: queue saturates, fetch stops, nothing lost afterwards
        redirect_to(32'h0000_0040);
        push_model(32'h0000_0040, 24);
        repeat (20) tick();
        chk("full_ren", 32'(ICACHE_ren), 32'd0);
        chk("full_valid", 32'(instr_valid), 32'd1);
        chk("full_instr", instr_o, 32'h0000_4001);
        drain(1'b0);

        // Stall for 3 cycles with a redirect in the 2nd
        redirect_to(32'h0000_00E0);
        ICACHE_stall = 1'b1;
        tick();
        chk("stall_addr", 32'(ICACHE_addr), 32'h0000_0038);
        chk("stall_valid", 32'(instr_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0140;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("stall_redir_addr", 32'(ICACHE_addr), 32'h0000_0050);
        chk("stall_redir_ren", 32'(ICACHE_ren), 32'd1);
        sb_q.delete();
        push_model(32'h0000_0140, 6);
        tick();
        ICACHE_stall = 1'b0;
        drain(1'b0);

        // Random program with random ready and stall
        redirect_to(32'h0000_0180);
        push_model(32'h0000_0180, 30);
        drain(1'b1);

        // Asynchronous reset with five halfwords queued, 32-bit half-present
        redirect_to(32'h0000_00A2);
        repeat (3) tick();
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        chk("pre_rst_instr", instr_o, 32'h0000_4009);
        chk("pre_rst_pc", instr_pc, 32'h0000_00A2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_instr", instr_o, 32'h0000_0000);
        chk("mid_rst_pc", instr_pc, 32'h0000_0000);
        chk("mid_rst_c", 32'(instr_compressed), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_rdata();
        #1;
        chk("restart_addr", 32'(ICACHE_addr), 32'd0);
        chk("restart_ren", 32'(ICACHE_ren), 32'd1);
        tick();
        chk("restart_valid", 32'(instr_valid), 32'd1);
        chk("restart_instr", instr_o, 32'h0050_0093);
        chk("restart_pc", instr_pc, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
